// File: rtl/scan_sequencer_pkg.sv
// Shared types and sizing constants for the scan sequencer and its slot selector.
package scan_sequencer_pkg;

    localparam int SLOT_COUNT = 3;
    localparam int DWELL_MAX  = 255;
    localparam int DWELL_W    = $clog2(DWELL_MAX + 1);

    typedef logic [SLOT_COUNT-1:0] slot_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        PRESENT
    } state_t;

endpackage

// File: rtl/scan_sequencer_slot_selector.sv
// Combinational next-slot search: lowest unmasked slot strictly above the current one.
// A current value of 000 means "before slot 0", so it also yields the first slot of a frame.
module slot_selector
    import scan_sequencer_pkg::*;
(
    input  slot_t current,
    input  slot_t mask,
    output slot_t next_slot,
    output logic  last
);

    always_comb begin
        logic past;
        next_slot = '0;
        past      = (current == '0);
        for (int i = 0; i < SLOT_COUNT; i++) begin
            if (past && !mask[i] && (next_slot == '0)) begin
                next_slot[i] = 1'b1;
            end
            if (current[i]) begin
                past = 1'b1;
            end
        end
    end

    assign last = (next_slot == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Steps a one-hot select across three mux slots, dwelling on each, and presents the
// captured frame to a consumer with a valid/ready handshake.
module scan_sequencer
    import scan_sequencer_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [SLOT_COUNT-1:0] skip_mask,
    input  logic                  mux_out,
    output logic [SLOT_COUNT-1:0] ring_counter,
    output logic [SLOT_COUNT-1:0] sample,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  frame_done,
    output logic                  busy
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    state_t             state, state_d;
    slot_t              ring_d, sample_d, working, working_d, mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_cnt, dwell_d;
    logic               valid_d, frame_done_d, busy_d;

    slot_t sel_current, sel_mask, next_slot, captured;
    logic  last_slot, start;

    // Outside SETTLE the selector searches the live mask from "no slot" to find a frame's first slot.
    assign sel_current = (state == SETTLE) ? ring_counter : '0;
    assign sel_mask    = (state == SETTLE) ? mask_q : skip_mask;
    assign captured    = working | (ring_counter & {SLOT_COUNT{mux_out}});

    slot_selector u_slot_selector (
        .current   (sel_current),
        .mask      (sel_mask),
        .next_slot (next_slot),
        .last      (last_slot)
    );

    // NOTE: every next-state value gets a default first, otherwise a path that skips an assignment infers a latch.
    always_comb begin
        state_d      = state;
        ring_d       = ring_counter;
        sample_d     = sample;
        valid_d      = sample_valid;
        working_d    = working;
        mask_d       = mask_q;
        dwell_d      = dwell_cnt;
        frame_done_d = 1'b0;
        start        = 1'b0;

        unique case (state)
            IDLE: begin
                ring_d = '0;
                start  = enable && (skip_mask != '1);
            end
            SETTLE: begin
                if (!enable) begin
                    state_d   = IDLE;
                    ring_d    = '0;
                    working_d = '0;
                    dwell_d   = '0;
                end else if (dwell_cnt == DWELL_LAST) begin
                    dwell_d = '0;
                    if (!last_slot) begin
                        ring_d    = next_slot;
                        working_d = captured;
                    end else begin
                        ring_d       = '0;
                        sample_d     = captured;
                        valid_d      = 1'b1;
                        frame_done_d = 1'b1;
                        working_d    = '0;
                        state_d      = PRESENT;
                    end
                end else begin
                    dwell_d = dwell_cnt + 1'b1;
                end
            end
            PRESENT: begin
                if (sample_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    start   = enable && (skip_mask != '1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d   = SETTLE;
            mask_d    = skip_mask;
            ring_d    = next_slot;
            dwell_d   = '0;
            working_d = '0;
        end

        busy_d = (state_d == SETTLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ring_counter <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
            working      <= '0;
            mask_q       <= '0;
            dwell_cnt    <= '0;
        end else begin
            state        <= state_d;
            ring_counter <= ring_d;
            sample       <= sample_d;
            sample_valid <= valid_d;
            frame_done   <= frame_done_d;
            busy         <= busy_d;
            working      <= working_d;
            mask_q       <= mask_d;
            dwell_cnt    <= dwell_d;
        end
    end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter: DWELL_CYCLES, default 4, clocks each slot stays selected before sampling; legal range 1..255.
REQ-002 Ports: one clock; reset is asynchronous and active-low; port names clk and rst_n.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  level; 1 = run scan frames continuously.
REQ-006 skip_mask  input  3  1 = slot excluded from the frame; sampled only at frame start.
REQ-007 mux_out  input  1  selected data bit returned by the downstream 3x1 multiplexer.
REQ-008 ring_counter  output  3  one-hot slot select driving the multiplexer; 000 = none.
REQ-009 sample  output  3  captured frame, bit i = mux_out while slot i selected; masked bits 0.
REQ-010 sample_valid  output  1  sample holds a complete frame.
REQ-011 sample_ready  input  1  consumer accepts sample when sample_valid=1.
REQ-012 frame_done  output  1  one-cycle pulse when a frame completes.
REQ-013 busy  output  1  1 while state is SETTLE.

Function
REQ-014 FSM states: IDLE, SETTLE, PRESENT; all outputs registered.
REQ-015 ring_counter SHALL never have more than one bit set.
REQ-016 IDLE: ring_counter=000; on enable=1 with skip_mask!=111, latch skip_mask, select the lowest-index unmasked slot, clear dwell counter and working register, enter SETTLE.
REQ-017 IDLE with skip_mask=111: remain in IDLE, no frame_done, no sample_valid.
REQ-018 SETTLE: each selected slot stays selected for exactly DWELL_CYCLES clocks; mux_out captured into working bit at the clock edge ending the last dwell cycle.
REQ-019 On that edge, if a higher-index unmasked slot exists, ring_counter moves directly to it (masked slots never selected) and the dwell counter clears.
REQ-020 Otherwise, on that same edge: ring_counter<=000, sample<=working value including the final capture, sample_valid<=1, frame_done<=1 for one cycle, enter PRESENT.
REQ-021 Latency: sample_valid rises N*DWELL_CYCLES clocks after the first slot is selected, N = unmasked slot count.
REQ-022 PRESENT: sample and sample_valid hold stable until sample_valid&&sample_ready.
REQ-023 On handshake: sample_valid<=0; if enable=1 the next frame starts on that same edge as in REQ-016 (no idle cycle); otherwise go IDLE.
REQ-024 sample_ready=1 outside PRESENT is ignored.
REQ-025 enable=0 in SETTLE aborts: next edge ring_counter<=000, working discarded, no frame_done, state IDLE, sample and sample_valid unchanged.
REQ-026 enable=0 in PRESENT: pending sample still held until consumed, then IDLE.
REQ-027 skip_mask changes mid-frame SHALL not affect the current frame.

Reset
REQ-028 rst_n=0 asynchronously forces: state IDLE, ring_counter=000, sample=000, sample_valid=0, frame_done=0, busy=0, dwell counter and working register 0.
REQ-029 Reset mid-frame discards the frame; first frame after release starts per REQ-016.

Structure
REQ-030 Shared package holds the FSM state enum, SLOT_COUNT=3, and the dwell counter width derived from DWELL_CYCLES max.
REQ-031 One sub-module, slot_selector: combinational, given current one-hot slot and latched mask returns next unmasked one-hot slot and a last-slot flag.

Verification
REQ-032 DWELL_CYCLES=4, mask=000, mux_out fed by model of bits {1,0,1} -> ring_counter 001,010,100 for 4 clocks each, sample=101 with frame_done after 12 cycles.
REQ-033 mask=010 -> ring_counter 001 then 100, never 010; sample bit1=0; sample_valid after 8 cycles.
REQ-034 sample_ready held 0 for 20 cycles -> sample stable, ring_counter=000; release ready with enable=1 -> next frame slot 001 selected on the same edge.
REQ-035 enable dropped on cycle 6 of a frame -> ring_counter=000 next cycle, no frame_done, sample_valid stays 0.
REQ-036 rst_n pulsed low asynchronously mid-SETTLE -> all outputs 0 immediately; mask=111 afterwards -> stays IDLE indefinitely.
